// File: rtl/nios_sys_mem_pkg.sv
// Shared definitions for the pipelined on-chip RAM slave: FSM state codes,
// legal read-latency bounds and the byte-lane count helper.
package nios_sys_mem_pkg;

  typedef logic [0:0] state_t;

  localparam state_t ST_CLEAR = 1'b0;
  localparam state_t ST_READY = 1'b1;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  function automatic int num_bytes(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/nios_sys_onchip_ram_pipelined_if.sv
// Avalon-MM slave bundle (s1) for the pipelined on-chip RAM, including the
// clock-enable sideband and clear-engine status.
interface nios_sys_onchip_ram_pipelined_if
  import nios_sys_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
);

  logic [ADDR_WIDTH-1:0]            address;
  logic [num_bytes(DATA_WIDTH)-1:0] byteenable;
  logic                             chipselect;
  logic                             read;
  logic                             write;
  logic [DATA_WIDTH-1:0]            writedata;
  logic                             clken;
  logic [DATA_WIDTH-1:0]            readdata;
  logic                             readdatavalid;
  logic                             waitrequest;
  logic                             clear_busy;

  modport master (
    output address, byteenable, chipselect, read, write, writedata, clken,
    input  readdata, readdatavalid, waitrequest, clear_busy
  );

  modport slave (
    input  address, byteenable, chipselect, read, write, writedata, clken,
    output readdata, readdatavalid, waitrequest, clear_busy
  );

endinterface

// File: rtl/nios_sys_ram_array.sv
// Single-port synchronous RAM with byte-lane write enables and a registered,
// read-enabled output port; structured for block-RAM inference.
module nios_sys_ram_array
  import nios_sys_mem_pkg::*;
#(
  parameter int    DATA_WIDTH = 32,
  parameter int    ADDR_WIDTH = 12,
  parameter string INIT_FILE  = ""
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             we,
  input  logic                             re,
  input  logic [ADDR_WIDTH-1:0]            addr,
  input  logic [num_bytes(DATA_WIDTH)-1:0] be,
  input  logic [DATA_WIDTH-1:0]            wdata,
  output logic [DATA_WIDTH-1:0]            rdata
);

  localparam int NB = num_bytes(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Output register only loads on a read, so readdata holds between responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/nios_sys_onchip_ram_pipelined.sv
// Pipelined on-chip RAM Avalon-MM slave: clear-after-reset FSM, request
// accept logic and a 1- or 2-stage read-response pipeline stalled by clken.
module nios_sys_onchip_ram_pipelined
  import nios_sys_mem_pkg::*;
#(
  parameter int    DATA_WIDTH     = 32,
  parameter int    ADDR_WIDTH     = 12,
  parameter int    READ_LATENCY   = 1,
  parameter int    CLEAR_ON_RESET = 0,
  parameter string INIT_FILE      = ""
) (
  input logic clk,
  input logic reset_n,
  nios_sys_onchip_ram_pipelined_if.slave s1
);

  // state    | meaning
  // ST_CLEAR | zeroing one word per enabled cycle; host held off
  // ST_READY | normal slave operation

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

  generate
    if (DATA_WIDTH < 8 || DATA_WIDTH > 128 || (DATA_WIDTH % 8) != 0) begin : g_bad_width
      $error("DATA_WIDTH must be a multiple of 8 in the range 8..128");
    end
    if (READ_LATENCY < RD_LAT_MIN || READ_LATENCY > RD_LAT_MAX) begin : g_bad_latency
      $error("READ_LATENCY must be 1 or 2");
    end
  endgenerate

  state_t                           state;
  logic [ADDR_WIDTH-1:0]            clr_ptr;
  logic                             in_clear;
  logic                             wait_req;
  logic                             acc;
  logic                             acc_rd;
  logic                             acc_wr;
  logic                             ram_we;
  logic [ADDR_WIDTH-1:0]            ram_addr;
  logic [num_bytes(DATA_WIDTH)-1:0] ram_be;
  logic [DATA_WIDTH-1:0]            ram_wd;
  logic [DATA_WIDTH-1:0]            ram_q;
  logic                             rd_vld;

  assign in_clear = (state == ST_CLEAR);

  // Reset forces waitrequest high even when the FSM resets straight to READY.
  assign wait_req      = ~reset_n | in_clear | ~s1.clken;
  assign s1.waitrequest = wait_req;
  assign s1.clear_busy  = reset_n & in_clear;

  assign acc    = s1.chipselect & (s1.read | s1.write) & ~wait_req;
  assign acc_wr = acc & s1.write;
  assign acc_rd = acc & s1.read & ~s1.write;

  assign ram_we   = (in_clear & s1.clken) | acc_wr;
  assign ram_addr = in_clear ? clr_ptr : s1.address;
  assign ram_be   = in_clear ? '1 : s1.byteenable;
  assign ram_wd   = in_clear ? '0 : s1.writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      clr_ptr <= '0;
    end else if (s1.clken && in_clear) begin
      if (clr_ptr == LAST_ADDR) state <= ST_READY;
      else clr_ptr <= clr_ptr + ADDR_WIDTH'(1);
    end
  end

  nios_sys_ram_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .INIT_FILE  ((CLEAR_ON_RESET != 0) ? "" : INIT_FILE)
  ) u_array (
    .clk   (clk),
    .rst_n (reset_n),
    .we    (ram_we),
    .re    (acc_rd),
    .addr  (ram_addr),
    .be    (ram_be),
    .wdata (ram_wd),
    .rdata (ram_q)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rd_vld <= 1'b0;
    else if (s1.clken) rd_vld <= acc_rd;
  end

  // Valid flags freeze while clken is low; the strobe itself is gated so a
  // held response is presented exactly once, on the first enabled cycle.
  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                  out_vld;
      logic [DATA_WIDTH-1:0] out_q;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          out_vld <= 1'b0;
          out_q   <= '0;
        end else if (s1.clken) begin
          out_vld <= rd_vld;
          if (rd_vld) out_q <= ram_q;
        end
      end

      assign s1.readdatavalid = out_vld & s1.clken;
      assign s1.readdata      = out_q;
    end else begin : g_lat1
      assign s1.readdatavalid = rd_vld & s1.clken;
      assign s1.readdata      = ram_q;
    end
  endgenerate

endmodule

// File: tb/tb_nios_sys_onchip_ram_pipelined.sv
// Bench for the pipelined on-chip RAM: one latency-1 and one latency-2 instance
// share identical stimulus and are compared against a queue-based reference.
module tb_nios_sys_onchip_ram_pipelined;

  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n = 1'b0;
  logic [AW-1:0] address;
  logic [3:0]    byteenable;
  logic          chipselect, read, write, clken;
  logic [31:0]   writedata;

  nios_sys_onchip_ram_pipelined_if #(.DATA_WIDTH(32), .ADDR_WIDTH(AW)) ifa ();
  nios_sys_onchip_ram_pipelined_if #(.DATA_WIDTH(32), .ADDR_WIDTH(AW)) ifb ();

  assign ifa.address = address;       assign ifb.address = address;
  assign ifa.byteenable = byteenable; assign ifb.byteenable = byteenable;
  assign ifa.chipselect = chipselect; assign ifb.chipselect = chipselect;
  assign ifa.read = read;             assign ifb.read = read;
  assign ifa.write = write;           assign ifb.write = write;
  assign ifa.writedata = writedata;   assign ifb.writedata = writedata;
  assign ifa.clken = clken;           assign ifb.clken = clken;

  nios_sys_onchip_ram_pipelined #(
    .DATA_WIDTH(32), .ADDR_WIDTH(AW), .READ_LATENCY(1), .CLEAR_ON_RESET(1), .INIT_FILE("")
  ) dut_a (.clk(clk), .reset_n(reset_n), .s1(ifa));

  nios_sys_onchip_ram_pipelined #(
    .DATA_WIDTH(32), .ADDR_WIDTH(AW), .READ_LATENCY(2), .CLEAR_ON_RESET(1), .INIT_FILE("")
  ) dut_b (.clk(clk), .reset_n(reset_n), .s1(ifb));

  logic        obs_rdv [2];
  logic        obs_wait[2];
  logic        obs_cb  [2];
  logic [31:0] obs_data[2];
  assign obs_rdv[0] = ifa.readdatavalid; assign obs_rdv[1] = ifb.readdatavalid;
  assign obs_wait[0] = ifa.waitrequest;  assign obs_wait[1] = ifb.waitrequest;
  assign obs_cb[0] = ifa.clear_busy;     assign obs_cb[1] = ifb.clear_busy;
  assign obs_data[0] = ifa.readdata;     assign obs_data[1] = ifb.readdata;

  // Reference: a word array, the number of enabled cycles of clearing still
  // owed, and outstanding reads aged in enabled edges (instance d shows age d+1).
  typedef struct { logic [31:0] data; int age; } rsp_t;
  rsp_t        pend[$];
  logic [31:0] mem_m[DEPTH];
  int          clr_left = DEPTH;
  int          total = 0;
  int          passed = 0;

  typedef struct packed {
    logic cs; logic rd; logic wr; logic [AW-1:0] a; logic [3:0] be; logic [31:0] wd; logic ce;
  } stim_t;

  function automatic stim_t op(input logic cs, input logic rd, input logic wr, input logic [AW-1:0] a,
                               input logic [3:0] be, input logic [31:0] wd, input logic ce);
    stim_t t;
    t.cs = cs; t.rd = rd; t.wr = wr; t.a = a; t.be = be; t.wd = wd; t.ce = ce;
    return t;
  endfunction

  function automatic stim_t wr_op(input logic [AW-1:0] a, input logic [3:0] be, input logic [31:0] wd);
    return op(1'b1, 1'b0, 1'b1, a, be, wd, 1'b1);
  endfunction

  function automatic stim_t rd_op(input logic [AW-1:0] a);
    return op(1'b1, 1'b1, 1'b0, a, 4'h0, 32'h0, 1'b1);
  endfunction

  function automatic stim_t idle_op();
    return op(1'b0, 1'b0, 1'b0, '0, 4'h0, 32'h0, 1'b1);
  endfunction

  task automatic apply(input stim_t t);
    chipselect = t.cs; read = t.rd; write = t.wr; address = t.a;
    byteenable = t.be; writedata = t.wd; clken = t.ce;
  endtask

  function automatic logic exp_wait();
    return (!reset_n) || (clr_left != 0) || (!clken);
  endfunction

  function automatic logic exp_busy();
    return reset_n && (clr_left != 0);
  endfunction

  function automatic logic exp_rdv(input int d);
    logic hit = 1'b0;
    foreach (pend[i]) if (pend[i].age == d + 1) hit = 1'b1;
    return hit && reset_n && clken;
  endfunction

  function automatic logic [31:0] exp_data(input int d);
    logic [31:0] v = 32'h0;
    foreach (pend[i]) if (pend[i].age == d + 1) v = pend[i].data;
    return v;
  endfunction

  task automatic model_reset();
    clr_left = DEPTH;
    pend.delete();
  endtask

  task automatic model_edge();
    if (!reset_n || !clken) return;
    foreach (pend[i]) pend[i].age++;
    while (pend.size() != 0 && pend[0].age > 2) void'(pend.pop_front());
    if (clr_left != 0) begin
      mem_m[DEPTH - clr_left] = 32'h0;
      clr_left--;
    end else if (chipselect && write) begin
      for (int b = 0; b < 4; b++)
        if (byteenable[b]) mem_m[address][8*b +: 8] = writedata[8*b +: 8];
    end else if (chipselect && read) begin
      pend.push_back('{mem_m[address], 1});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    apply(idle_op());
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      total++;
      if (obs_wait[d] !== 1'b1 || obs_rdv[d] !== 1'b0 || obs_cb[d] !== 1'b0 || obs_data[d] !== 32'h0)
        $display("FAIL reset dut%0d wait/rdv/busy/data got %b/%b/%b/%h want 1/0/0/00000000",
                 d, obs_wait[d], obs_rdv[d], obs_cb[d], obs_data[d]);
      else passed++;
    end
  endtask

  task automatic test_clear();
    stim_t s[$];
    int    busy[2];
    int    pulses[2];
    logic  nonzero[2];
    busy = '{0, 0}; pulses = '{0, 0}; nonzero = '{1'b0, 1'b0};
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int c = 0; c < DEPTH + 3; c++) s.push_back(idle_op());
    for (int a = 0; a < DEPTH; a++) s.push_back(rd_op(AW'(a)));
    repeat (3) s.push_back(idle_op());
    foreach (s[c]) begin
      apply(s[c]);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        total++;
        if (obs_wait[d] !== exp_wait() || obs_cb[d] !== exp_busy() || obs_rdv[d] !== exp_rdv(d) ||
            (exp_rdv(d) && obs_data[d] !== exp_data(d)))
          $display("FAIL clear cyc%0d dut%0d wait/busy/rdv/data got %b/%b/%b/%h want %b/%b/%b/%h",
                   c, d, obs_wait[d], obs_cb[d], obs_rdv[d], obs_data[d],
                   exp_wait(), exp_busy(), exp_rdv(d), exp_data(d));
        else passed++;
        if (obs_cb[d] === 1'b1 && obs_wait[d] === 1'b1) busy[d]++;
        if (obs_rdv[d] === 1'b1) begin
          pulses[d]++;
          if (obs_data[d] !== 32'h0) nonzero[d] = 1'b1;
        end
      end
      tick();
    end
    for (int d = 0; d < 2; d++) begin
      total++;
      if (busy[d] != DEPTH || pulses[d] != DEPTH || nonzero[d])
        $display("FAIL clear_len dut%0d busy_cycles/read_pulses/nonzero got %0d/%0d/%b want 16/16/0",
                 d, busy[d], pulses[d], nonzero[d]);
      else passed++;
    end
  endtask

  task automatic test_byteenable();
    stim_t       s[$];
    int          pulses[2];
    logic [31:0] got[2];
    pulses = '{0, 0}; got = '{32'h0, 32'h0};
    s.push_back(wr_op(4'd5, 4'hF, 32'hDEADBEEF));
    s.push_back(wr_op(4'd5, 4'b0101, 32'h11223344));
    s.push_back(wr_op(4'd6, 4'h0, 32'hFFFFFFFF));
    s.push_back(rd_op(4'd5));
    s.push_back(rd_op(4'd6));
    repeat (3) s.push_back(idle_op());
    foreach (s[c]) begin
      apply(s[c]);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        total++;
        if (obs_wait[d] !== exp_wait() || obs_cb[d] !== exp_busy() || obs_rdv[d] !== exp_rdv(d) ||
            (exp_rdv(d) && obs_data[d] !== exp_data(d)))
          $display("FAIL byteenable cyc%0d dut%0d wait/busy/rdv/data got %b/%b/%b/%h want %b/%b/%b/%h",
                   c, d, obs_wait[d], obs_cb[d], obs_rdv[d], obs_data[d],
                   exp_wait(), exp_busy(), exp_rdv(d), exp_data(d));
        else passed++;
        if (obs_rdv[d] === 1'b1) begin
          if (pulses[d] == 0) got[d] = obs_data[d];
          pulses[d]++;
        end
      end
      tick();
    end
    for (int d = 0; d < 2; d++) begin
      total++;
      if (pulses[d] != 2 || got[d] !== 32'hDE22BE44)
        $display("FAIL byteenable_word dut%0d pulses/data got %0d/%h want 2/de22be44", d, pulses[d], got[d]);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    stim_t       s[$];
    int          pulses[2];
    int          first[2];
    logic [31:0] seq[2][3];
    pulses = '{0, 0}; first = '{-1, -1};
    s.push_back(wr_op(4'd1, 4'hF, 32'h0000000A));
    s.push_back(wr_op(4'd2, 4'hF, 32'h0000000B));
    s.push_back(wr_op(4'd3, 4'hF, 32'h0000000C));
    s.push_back(rd_op(4'd1));
    s.push_back(rd_op(4'd2));
    s.push_back(rd_op(4'd3));
    repeat (3) s.push_back(idle_op());
    foreach (s[c]) begin
      apply(s[c]);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        total++;
        if (obs_wait[d] !== exp_wait() || obs_cb[d] !== exp_busy() || obs_rdv[d] !== exp_rdv(d) ||
            (exp_rdv(d) && obs_data[d] !== exp_data(d)))
          $display("FAIL back_to_back cyc%0d dut%0d wait/busy/rdv/data got %b/%b/%b/%h want %b/%b/%b/%h",
                   c, d, obs_wait[d], obs_cb[d], obs_rdv[d], obs_data[d],
                   exp_wait(), exp_busy(), exp_rdv(d), exp_data(d));
        else passed++;
        if (obs_rdv[d] === 1'b1) begin
          if (pulses[d] == 0) first[d] = c;
          if (pulses[d] < 3) seq[d][pulses[d]] = obs_data[d];
          pulses[d]++;
        end
      end
      tick();
    end
    // First read goes in during cycle 3, so its strobe shows in cycle 3 + latency.
    for (int d = 0; d < 2; d++) begin
      total++;
      if (pulses[d] != 3 || first[d] != 4 + d || seq[d][0] !== 32'hA || seq[d][1] !== 32'hB || seq[d][2] !== 32'hC)
        $display("FAIL back_to_back_order dut%0d pulses/first/data got %0d/%0d/%h,%h,%h want 3/%0d/a,b,c",
                 d, pulses[d], first[d], seq[d][0], seq[d][1], seq[d][2], 4 + d);
      else passed++;
    end
  endtask

  task automatic test_read_after_write();
    stim_t       s[$];
    int          pulses[2];
    logic [31:0] got[2];
    pulses = '{0, 0}; got = '{32'h0, 32'h0};
    s.push_back(wr_op(4'd7, 4'hF, 32'h00000055));
    s.push_back(rd_op(4'd7));
    repeat (3) s.push_back(idle_op());
    foreach (s[c]) begin
      apply(s[c]);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        total++;
        if (obs_wait[d] !== exp_wait() || obs_cb[d] !== exp_busy() || obs_rdv[d] !== exp_rdv(d) ||
            (exp_rdv(d) && obs_data[d] !== exp_data(d)))
          $display("FAIL raw cyc%0d dut%0d wait/busy/rdv/data got %b/%b/%b/%h want %b/%b/%b/%h",
                   c, d, obs_wait[d], obs_cb[d], obs_rdv[d], obs_data[d],
                   exp_wait(), exp_busy(), exp_rdv(d), exp_data(d));
        else passed++;
        if (obs_rdv[d] === 1'b1) begin got[d] = obs_data[d]; pulses[d]++; end
      end
      tick();
    end
    for (int d = 0; d < 2; d++) begin
      total++;
      if (pulses[d] != 1 || got[d] !== 32'h00000055)
        $display("FAIL raw_word dut%0d pulses/data got %0d/%h want 1/00000055", d, pulses[d], got[d]);
      else passed++;
    end
  endtask

  task automatic test_stall();
    stim_t       s[$];
    int          pulses[2];
    int          stall_bad[2];
    logic [31:0] got[2];
    pulses = '{0, 0}; stall_bad = '{0, 0}; got = '{32'h0, 32'h0};
    s.push_back(rd_op(4'd5));
    repeat (3) s.push_back(op(1'b1, 1'b1, 1'b0, 4'd6, 4'h0, 32'h0, 1'b0));
    repeat (3) s.push_back(idle_op());
    foreach (s[c]) begin
      apply(s[c]);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        total++;
        if (obs_wait[d] !== exp_wait() || obs_cb[d] !== exp_busy() || obs_rdv[d] !== exp_rdv(d) ||
            (exp_rdv(d) && obs_data[d] !== exp_data(d)))
          $display("FAIL stall cyc%0d dut%0d wait/busy/rdv/data got %b/%b/%b/%h want %b/%b/%b/%h",
                   c, d, obs_wait[d], obs_cb[d], obs_rdv[d], obs_data[d],
                   exp_wait(), exp_busy(), exp_rdv(d), exp_data(d));
        else passed++;
        if (!s[c].ce && (obs_wait[d] !== 1'b1 || obs_rdv[d] !== 1'b0)) stall_bad[d]++;
        if (obs_rdv[d] === 1'b1) begin got[d] = obs_data[d]; pulses[d]++; end
      end
      tick();
    end
    for (int d = 0; d < 2; d++) begin
      total++;
      if (pulses[d] != 1 || stall_bad[d] != 0 || got[d] !== 32'hDE22BE44)
        $display("FAIL stall_resp dut%0d pulses/bad_stall_cycles/data got %0d/%0d/%h want 1/0/de22be44",
                 d, pulses[d], stall_bad[d], got[d]);
      else passed++;
    end
  endtask

  task automatic test_random();
    stim_t t;
    for (int c = 0; c < 400; c++) begin
      t = op($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
             AW'($urandom_range(0, DEPTH - 1)), 4'($urandom_range(0, 15)), $urandom,
             $urandom_range(0, 7) != 0);
      apply(t);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        total++;
        if (obs_wait[d] !== exp_wait() || obs_cb[d] !== exp_busy() || obs_rdv[d] !== exp_rdv(d) ||
            (exp_rdv(d) && obs_data[d] !== exp_data(d)))
          $display("FAIL random cyc%0d dut%0d wait/busy/rdv/data got %b/%b/%b/%h want %b/%b/%b/%h",
                   c, d, obs_wait[d], obs_cb[d], obs_rdv[d], obs_data[d],
                   exp_wait(), exp_busy(), exp_rdv(d), exp_data(d));
        else passed++;
      end
      tick();
    end
  endtask

  task automatic test_reset_abort();
    int busy[2];
    // Read in flight, then asynchronous reset between edges.
    apply(rd_op(4'd7));
    @(negedge clk);
    tick();
    apply(idle_op());
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    for (int d = 0; d < 2; d++) begin
      total++;
      if (obs_rdv[d] !== 1'b0 || obs_wait[d] !== 1'b1 || obs_cb[d] !== 1'b0)
        $display("FAIL abort_read dut%0d rdv/wait/busy got %b/%b/%b want 0/1/0", d, obs_rdv[d], obs_wait[d], obs_cb[d]);
      else passed++;
    end
    for (int phase = 0; phase < 2; phase++) begin
      busy = '{0, 0};
      @(posedge clk); #1;
      reset_n = 1'b1;
      for (int c = 0; c < ((phase == 0) ? 9 : DEPTH + 4); c++) begin
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
          total++;
          if (obs_wait[d] !== exp_wait() || obs_cb[d] !== exp_busy() || obs_rdv[d] !== exp_rdv(d))
            $display("FAIL abort_clear ph%0d cyc%0d dut%0d wait/busy/rdv got %b/%b/%b want %b/%b/%b",
                     phase, c, d, obs_wait[d], obs_cb[d], obs_rdv[d], exp_wait(), exp_busy(), exp_rdv(d));
          else passed++;
          if (obs_cb[d] === 1'b1) busy[d]++;
        end
        tick();
      end
      if (phase == 0) begin
        // Clear pointer now sits at 9: abort the clear mid-way.
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        for (int d = 0; d < 2; d++) begin
          total++;
          if (obs_cb[d] !== 1'b0 || obs_wait[d] !== 1'b1 || obs_rdv[d] !== 1'b0)
            $display("FAIL abort_busy dut%0d busy/wait/rdv got %b/%b/%b want 0/1/0", d, obs_cb[d], obs_wait[d], obs_rdv[d]);
          else passed++;
        end
      end else begin
        for (int d = 0; d < 2; d++) begin
          total++;
          if (busy[d] != DEPTH)
            $display("FAIL abort_restart dut%0d busy_cycles got %0d want 16", d, busy[d]);
          else passed++;
        end
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout simulation did not finish, got time %0t want < 100000", $time);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_clear();
    test_byteenable();
    test_back_to_back();
    test_read_after_write();
    test_stall();
    test_random();
    test_reset_abort();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/nios_sys_onchip_ram_pipelined.md
Name: nios_sys_onchip_ram_pipelined

Overview:
Parametrised successor to the single-port on-chip RAM Avalon-MM slave. Adds configurable width and depth, a pipelined read path with readdatavalid, and waitrequest flow control. Also adds an optional hardware clear engine that zeroes memory after reset. Sits on the Nios II system interconnect as a data/program memory slave (s1).

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of 8, range 8..128
ADDR_WIDTH, 12, word address width; DEPTH = 2**ADDR_WIDTH
READ_LATENCY, 1, cycles from read accept to readdatavalid; legal values 1 or 2 (2 adds an output register)
CLEAR_ON_RESET, 0, 1 = zero every word after reset before accepting traffic
INIT_FILE, "", hex image loaded at elaboration; ignored when CLEAR_ON_RESET = 1

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
address  in  ADDR_WIDTH  word address
byteenable  in  DATA_WIDTH/8  write lane enables
chipselect  in  1  slave select
read  in  1  read request
write  in  1  write request
writedata  in  DATA_WIDTH  write data
clken  in  1  clock enable; 0 stalls the block
readdata  out  DATA_WIDTH  read data, valid only when readdatavalid = 1
readdatavalid  out  1  read response strobe
waitrequest  out  1  1 = request not accepted this cycle
clear_busy  out  1  clear engine active

Behaviour:
- Reset (reset_n = 0, async): readdata = 0, readdatavalid = 0, waitrequest = 1, clear_busy = 0; read pipeline flushed; FSM -> CLEAR if CLEAR_ON_RESET = 1, else READY.
- FSM states: CLEAR, READY.
- CLEAR:
  - clear pointer starts at 0 and writes all-zero words, one per enabled cycle.
  - clear_busy = 1 and waitrequest = 1 throughout.
  - Host requests are ignored; no readdatavalid is generated.
  - After the write to DEPTH-1, go to READY on the next edge. Clear takes exactly DEPTH enabled cycles.
- READY:
  - waitrequest = ~clken, combinational.
  - A request is accepted when chipselect & (read | write) & ~waitrequest.
- Write: on accept, lanes with byteenable[i] = 1 update bits [8i+7:8i] at the clock edge; other lanes are unchanged. byteenable = 0 performs no change but the write is still accepted.
- Read:
  - Accepted read at edge N returns readdatavalid = 1 with the word for 1 cycle at edge N+READ_LATENCY.
  - Fully pipelined: one read per cycle, responses in order, no gaps added.
- read and write both asserted: write performed, read dropped, no readdatavalid.
- Read after write to the same address in the next cycle returns the new data. No same-cycle hazard exists because simultaneous read and write is resolved as above.
- clken = 0: no accept, no memory update, no clear progress. The read pipeline holds its state, readdatavalid is forced to 0, and pending responses emerge once clken returns to 1.
- readdata holds its last value when readdatavalid = 0; the bench must not check it in that case.
- Address wrap: not applicable (full decode); the clear pointer saturates at DEPTH-1 and leaves CLEAR.
- Reset mid-CLEAR or mid-read: async abort, pipeline flushed, clear restarts from 0 after release. Memory contents are undefined if CLEAR_ON_RESET = 0.
- Elaboration error on illegal DATA_WIDTH or READ_LATENCY.

Decomposition:
- Shared package nios_sys_mem_pkg: FSM state enum (ST_CLEAR, ST_READY), READ_LATENCY legal-value constants, and a BYTES(DATA_WIDTH) helper function.
- One sub-module, nios_sys_ram_array: byte-lane-enabled synchronous single-port array with INIT_FILE support, coded for block-RAM inference.
- The top level holds the FSM, clear pointer, accept logic and latency pipeline.

Test Plan:
- CLEAR_ON_RESET=1, ADDR_WIDTH=4: release reset_n -> clear_busy = 1 and waitrequest = 1 for exactly 16 cycles, then both 0; reads of addresses 0..15 return 0x00000000.
- Write 0xDEADBEEF to addr 5 with byteenable 4'hF, then write 0x11223344 with byteenable 4'b0101 -> read of addr 5 returns 0xDE22BE44.
- READ_LATENCY=2: back-to-back reads of addr 1, 2, 3 holding 0xA, 0xB, 0xC -> readdatavalid high for 3 consecutive cycles starting 2 edges after the first accept, data 0xA, 0xB, 0xC in order.
- Write 0x55 to addr 7, then read addr 7 the next cycle -> readdata = 0x00000055.
- Read accepted, then clken = 0 for 3 cycles -> waitrequest = 1 and readdatavalid = 0 throughout; after clken returns to 1 the response arrives with the correct data, exactly one pulse.
- Assert reset_n = 0 while a read is in flight and during CLEAR at pointer 9 -> readdatavalid drops immediately, no late response after release, and the clear restarts at 0, taking the full DEPTH cycles.
